// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues single-outstanding word reads
// to instruction memory and presents each fetched instruction with its PC to IF/ID.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic        instr_valid
);

  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t      state_r;
  logic [31:0] fpc_r;
  logic        req_s;
  logic        load_s;

  // Only request when the slot will be empty by the time data returns, so no skid buffer is needed.
  assign req_s     = (state_r == ST_REQ) && !reset && !redirect && (!instr_valid || !stall);
  assign load_s    = (state_r == ST_WAIT) && imem_rvalid && !redirect;
  assign imem_req  = req_s;
  assign imem_addr = fpc_r;

  // Fetch FSM, fetch PC and output slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_REQ;
      fpc_r       <= RESET_PC;
      instr_out   <= NOP_INSTR;
      pc_out      <= 32'h0000_0000;
      instr_valid <= 1'b0;
    end else if (redirect) begin
      // Redirect wins over stall; a response arriving this edge is the stale one and is dropped.
      fpc_r       <= redirect_pc & 32'hFFFF_FFFC;
      instr_out   <= NOP_INSTR;
      instr_valid <= 1'b0;
      case (state_r)
        ST_REQ:   state_r <= ST_REQ;
        ST_WAIT:  state_r <= imem_rvalid ? ST_REQ : ST_DRAIN;
        ST_DRAIN: state_r <= imem_rvalid ? ST_REQ : ST_DRAIN;
        default:  state_r <= ST_REQ;
      endcase
    end else begin
      if (load_s) begin
        instr_out   <= imem_rdata;
        pc_out      <= fpc_r;
        instr_valid <= 1'b1;
        fpc_r       <= fpc_r + 32'd4;
      end else if (!stall) begin
        instr_out   <= NOP_INSTR;
        instr_valid <= 1'b0;
      end else begin
        instr_valid <= instr_valid;
      end
      case (state_r)
        ST_REQ:   state_r <= (req_s && imem_ready) ? ST_WAIT : ST_REQ;
        ST_WAIT:  state_r <= imem_rvalid ? ST_REQ : ST_WAIT;
        ST_DRAIN: state_r <= imem_rvalid ? ST_REQ : ST_DRAIN;
        default:  state_r <= ST_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: a cycle-level memory model returns addr^0xA5A5_0000,
// and a monitor checks accepted request addresses and newly loaded slots against queues.
module tb_if_fetch_unit;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } slot_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic        instr_valid;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_req[$];
  slot_t       exp_slot[$];

  // memory model state
  int          lat     = 1;
  int          rem     = 0;
  logic        pending = 1'b0;
  logic [31:0] paddr   = 32'h0;
  logic        prev_valid = 1'b0;

  if_fetch_unit #(
    .RESET_PC  (32'h0000_0100),
    .NOP_INSTR (NOP)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr_out   (instr_out),
    .pc_out      (pc_out),
    .instr_valid (instr_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Advance one clock; the memory model accepts/returns around the edge.
  task automatic tick();
    logic        acc;
    logic        rst;
    logic [31:0] a;
    @(negedge clk);
    acc = imem_req && imem_ready;
    a   = imem_addr;
    rst = reset;
    @(posedge clk);
    #1;
    imem_rvalid = 1'b0;
    if (rst) begin
      pending = 1'b0;
    end else if (acc) begin
      check32("one_outstanding", {31'd0, pending}, 32'd0);
      pending = 1'b1;
      rem     = lat;
      paddr   = a;
    end
    if (pending) begin
      rem--;
      if (rem == 0) begin
        pending     = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = paddr ^ 32'hA5A5_0000;
      end
    end
  endtask

  // Monitor: compare accepted requests and each newly loaded slot against the queues.
  always @(negedge clk) begin
    slot_t s;
    logic [31:0] e;
    if (imem_req && imem_ready) begin
      if (exp_req.size() == 0) begin
        check32("unexpected_req", imem_addr, 32'hXXXX_XXXX);
      end else begin
        e = exp_req.pop_front();
        check32("req_addr", imem_addr, e);
      end
    end
    if (!reset && instr_valid && !prev_valid) begin
      if (exp_slot.size() == 0) begin
        check32("unexpected_slot_pc", pc_out, 32'hXXXX_XXXX);
      end else begin
        s = exp_slot.pop_front();
        check32("slot_instr", instr_out, s.instr);
        check32("slot_pc", pc_out, s.pc);
      end
    end
    prev_valid <= instr_valid;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    imem_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'h0;

    tick(); tick();
    #2;
    check32("rst_instr", instr_out, NOP);
    check32("rst_pc", pc_out, 32'h0);
    check32("rst_valid", {31'd0, instr_valid}, 32'd0);
    check32("rst_req", {31'd0, imem_req}, 32'd0);

    // zero-wait stream, then a 4-cycle stall on the 0x104 slot
    exp_req.push_back(32'h0000_0100);
    exp_req.push_back(32'h0000_0104);
    exp_req.push_back(32'h0000_0108);
    exp_slot.push_back('{32'hA5A5_0100, 32'h0000_0100});
    exp_slot.push_back('{32'hA5A5_0104, 32'h0000_0104});
    exp_slot.push_back('{32'hA5A5_0108, 32'h0000_0108});
    reset = 1'b0;                      // c0
    tick(); #2;                        // c1: waiting on data
    check32("wait_req_low", {31'd0, imem_req}, 32'd0);
    tick(); tick();                    // c3
    for (int i = 0; i < 4; i++) begin  // c4..c7
      tick();
      stall = 1'b1;
      #2;
      check32("stall_req", {31'd0, imem_req}, 32'd0);
      check32("stall_instr", instr_out, 32'hA5A5_0104);
      check32("stall_pc", pc_out, 32'h0000_0104);
    end
    tick(); stall = 1'b0; #2;          // c8
    check32("unstall_req", {31'd0, imem_req}, 32'd1);
    tick();                            // c9

    // latency 3, redirect while the 0x10C request is outstanding
    exp_req.push_back(32'h0000_010C);
    exp_req.push_back(32'h0000_0200);
    exp_slot.push_back('{32'hA5A5_0200, 32'h0000_0200});
    tick(); lat = 3;                   // c10
    tick(); redirect = 1'b1; redirect_pc = 32'h0000_0200;  // c11
    for (int i = 0; i < 2; i++) begin  // c12, c13: draining
      tick(); redirect = 1'b0; #2;
      check32("drain_req", {31'd0, imem_req}, 32'd0);
      check32("drain_valid", {31'd0, instr_valid}, 32'd0);
    end
    tick(); #2;                        // c14
    check32("redir_addr", imem_addr, 32'h0000_0200);
    tick(); tick(); #2;                // c16
    check32("redir_wait_valid", {31'd0, instr_valid}, 32'd0);
    tick();                            // c17

    // redirect coincident with rvalid; target is word-aligned
    exp_req.push_back(32'h0000_0204);
    exp_req.push_back(32'h0000_0300);
    exp_slot.push_back('{32'hA5A5_0300, 32'h0000_0300});
    tick(); lat = 1;                   // c18
    tick(); redirect = 1'b1; redirect_pc = 32'h0000_0303;  // c19
    tick(); redirect = 1'b0; #2;       // c20
    check32("discard_valid", {31'd0, instr_valid}, 32'd0);
    check32("aligned_addr", imem_addr, 32'h0000_0300);
    tick();                            // c21

    // redirect under stall flushes a valid slot; then PC wrap
    exp_req.push_back(32'hFFFF_FFFC);
    exp_req.push_back(32'h0000_0000);
    exp_slot.push_back('{32'h5A5A_FFFC, 32'hFFFF_FFFC});
    exp_slot.push_back('{32'hA5A5_0000, 32'h0000_0000});
    tick();                            // c22
    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    #2;
    check32("stall_redir_req", {31'd0, imem_req}, 32'd0);
    tick(); redirect = 1'b0; #2;       // c23
    check32("flush_valid", {31'd0, instr_valid}, 32'd0);
    check32("flush_instr", instr_out, NOP);
    check32("flush_pc_hold", pc_out, 32'h0000_0300);
    check32("flush_fpc", imem_addr, 32'hFFFF_FFFC);
    check32("empty_stall_req", {31'd0, imem_req}, 32'd1);
    tick();                            // c24: completes into slot despite stall
    tick(); stall = 1'b0; #2;          // c25
    check32("wrap_pc_out", pc_out, 32'hFFFF_FFFC);
    check32("wrap_addr", imem_addr, 32'h0000_0000);
    tick();                            // c26

    // reset while a request is outstanding; a late rvalid is ignored
    exp_req.push_back(32'h0000_0004);
    tick(); lat = 2;                   // c27
    tick(); reset = 1'b1; #2;          // c28
    check32("rst_wait_req", {31'd0, imem_req}, 32'd0);
    tick(); #2;                        // c29
    check32("rst2_instr", instr_out, NOP);
    check32("rst2_pc", pc_out, 32'h0);
    check32("rst2_valid", {31'd0, instr_valid}, 32'd0);
    check32("rst2_req", {31'd0, imem_req}, 32'd0);
    check32("rst2_addr", imem_addr, 32'h0000_0100);
    reset = 1'b0; imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    exp_req.push_back(32'h0000_0100);
    exp_slot.push_back('{32'hA5A5_0100, 32'h0000_0100});
    tick(); #2;                        // c30
    check32("late_valid", {31'd0, instr_valid}, 32'd0);
    check32("late_instr", instr_out, NOP);
    check32("late_pc", pc_out, 32'h0);
    lat = 1; imem_ready = 1'b1;
    tick(); tick(); imem_ready = 1'b0; // c32
    tick(); tick(); #2;

    check32("req_queue_left", exp_req.size(), 32'd0);
    check32("slot_queue_left", exp_slot.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
